// File: rtl/axi_slave_resp_push_fsm.sv
// Response-path push stage: turns completion headers and data beats into AXI R-channel
// beats written to the slave response buffer, tracking buffer occupancy to avoid overrun.
module axi_slave_resp_push_fsm #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned MAX_COUNT = 10,
    localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cpl_valid,
    output logic              cpl_ready,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [LEN_W-1:0]  cpl_len,
    input  logic              cpl_err,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATA_W-1:0] dat_data,
    output logic              buf_wr_en,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic [TAG_W-1:0]  buf_wr_id,
    output logic [1:0]        buf_wr_resp,
    output logic              buf_wr_last,
    input  logic              buf_rd_en,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                cpl_ready_q, cpl_ready_d;
    logic                dat_ready_q, dat_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [TAG_W-1:0]    wr_id_q, wr_id_d;
    logic [1:0]          wr_resp_q, wr_resp_d;
    logic                wr_last_q, wr_last_d;
    logic                push, pop, last_beat;

    // Next-state, beat push and occupancy tracking.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_id_d    = wr_id_q;
        wr_resp_d  = wr_resp_q;
        wr_last_d  = wr_last_q;
        push       = 1'b0;
        last_beat  = (beat_cnt_q == len_q);

        unique case (state_q)
            S_IDLE: begin
                if (cpl_valid && cpl_ready_q) begin
                    tag_d      = cpl_tag;
                    len_d      = cpl_len;
                    beat_cnt_d = '0;
                    state_d    = cpl_err ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (dat_valid && dat_ready_q) begin
                    push      = 1'b1;
                    wr_data_d = dat_data;
                    wr_resp_d = RESP_OKAY;
                end
            end
            S_ERR: begin
                if (!full_q) begin
                    push      = 1'b1;
                    wr_data_d = '0;
                    wr_resp_d = RESP_SLVERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_en_d    = 1'b1;
            wr_id_d    = tag_q;
            wr_last_d  = last_beat;
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
            if (last_beat) begin
                state_d = S_IDLE;
            end
        end

        // A pop against an empty buffer is ignored so the counter never wraps.
        pop = buf_rd_en && !empty_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d      = (count_d == CNT_W'(MAX_COUNT));
        empty_d     = (count_d == '0);
        cpl_ready_d = (state_d == S_IDLE);
        dat_ready_d = (state_d == S_DATA) && !full_d;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= S_IDLE;
            tag_q       <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            cpl_ready_q <= 1'b0;
            dat_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_id_q     <= '0;
            wr_resp_q   <= '0;
            wr_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            cpl_ready_q <= cpl_ready_d;
            dat_ready_q <= dat_ready_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_id_q     <= wr_id_d;
            wr_resp_q   <= wr_resp_d;
            wr_last_q   <= wr_last_d;
        end
    end

    assign cpl_ready   = cpl_ready_q;
    assign dat_ready   = dat_ready_q;
    assign buf_wr_en   = wr_en_q;
    assign buf_wr_data = wr_data_q;
    assign buf_wr_id   = wr_id_q;
    assign buf_wr_resp = wr_resp_q;
    assign buf_wr_last = wr_last_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_axi_slave_resp_push_fsm.sv
// Self-checking bench for axi_slave_resp_push_fsm: directed scenarios plus randomized
// traffic, compared against a beat-level scoreboard and occupancy model.
module tb_axi_slave_resp_push_fsm;

    localparam int MAX   = 10;
    localparam int CNT_W = $clog2(MAX + 1);

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   id;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    logic             clk;
    logic             arst;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [7:0]       cpl_tag;
    logic [7:0]       cpl_len;
    logic             cpl_err;
    logic             dat_valid;
    logic             dat_ready;
    logic [255:0]     dat_data;
    logic             buf_wr_en;
    logic [255:0]     buf_wr_data;
    logic [7:0]       buf_wr_id;
    logic [1:0]       buf_wr_resp;
    logic             buf_wr_last;
    logic             buf_rd_en;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int checks   = 0;
    int failures = 0;

    axi_slave_resp_push_fsm dut (
        .clk(clk), .arst(arst),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
        .cpl_len(cpl_len), .cpl_err(cpl_err),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data), .buf_wr_id(buf_wr_id),
        .buf_wr_resp(buf_wr_resp), .buf_wr_last(buf_wr_last),
        .buf_rd_en(buf_rd_en), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a completion is a number of outstanding beats; the buffer is an integer.
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    m_occ, m_left, m_mode;   // m_mode: 0 waiting for header, 1 data beats, 2 error beats
    logic [7:0] m_tag;
    bit    m_cpl_ready, m_dat_ready, m_push, m_pop;
    beat_t m_b;
    int    max_seen = 0;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_occ = 0; m_left = 0; m_mode = 0; m_cpl_ready = 0; m_dat_ready = 0;
        end else begin
            m_push = 0;
            m_b    = '0;
            if (m_mode == 0) begin
                if (cpl_valid && m_cpl_ready) begin
                    m_tag  = cpl_tag;
                    m_left = int'(cpl_len) + 1;
                    m_mode = cpl_err ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (dat_valid && m_dat_ready) begin
                    m_push = 1; m_b.data = dat_data; m_b.resp = 2'b00;
                end
            end else if (m_occ < MAX) begin
                m_push = 1; m_b.data = '0; m_b.resp = 2'b10;
            end
            m_pop = buf_rd_en && (m_occ > 0);
            if (m_push) begin
                m_b.id   = m_tag;
                m_b.last = (m_left == 1);
                exp_q.push_back(m_b);
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            m_occ       = m_occ + int'(m_push) - int'(m_pop);
            m_cpl_ready = (m_mode == 0);
            m_dat_ready = (m_mode == 1) && (m_occ < MAX);
        end
    end

    // Record every buffer write shortly after the edge that registers it.
    always @(posedge clk) begin
        #1;
        if (buf_wr_en === 1'b1)
            obs_q.push_back({buf_wr_data, buf_wr_id, buf_wr_resp, buf_wr_last});
        if (int'(count) > max_seen) max_seen = int'(count);
    end

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick(input int vprob, input int rprob);
        dat_valid = (int'($urandom_range(99)) < vprob);
        dat_data  = rand_data();
        buf_rd_en = (int'($urandom_range(99)) < rprob);
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] tag, input logic [7:0] len, input logic err,
                            output bit ok);
        ok = 0;
        cpl_valid = 1'b1; cpl_tag = tag; cpl_len = len; cpl_err = err; dat_valid = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = (cpl_ready === 1'b1);
            @(negedge clk);
        end
        cpl_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b0; cpl_valid = 0; cpl_tag = 0; cpl_len = 0; cpl_err = 0;
        dat_valid = 0; dat_data = '0; buf_rd_en = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({count, empty, full, buf_wr_en, cpl_ready, dat_ready} !== {CNT_W'(0), 5'b10000}) begin
            failures++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b wr_en=%b cpl_ready=%b dat_ready=%b, want 0 1 0 0 0 0",
                     count, empty, full, buf_wr_en, cpl_ready, dat_ready);
        end
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if (cpl_ready !== 1'b1 || dat_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cpl_ready=%b dat_ready=%b, want 1 0", cpl_ready, dat_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        send_hdr(8'h5A, 8'd3, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_hdr: header not accepted, want accepted"); end
        repeat (8) tick(100, 0);
        checks++;
        if (obs_q.size() != 4) begin
            failures++; $display("FAIL basic_beats: got %0d pushes, want 4", obs_q.size());
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].id !== 8'h5A || obs_q[i].resp !== 2'b00 || obs_q[i].last !== (i == 3)) begin
                failures++;
                $display("FAIL basic_fields[%0d]: id=%h resp=%b last=%b, want 5a 00 %b",
                         i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, (i == 3));
            end
        end
        checks++;
        if (count !== CNT_W'(4) || cpl_ready !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: count=%0d cpl_ready=%b empty=%b, want 4 1 0", count, cpl_ready, empty);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_scoreboard: beat %0d differs from model", i);
            end
        end
        obs_q.delete(); exp_q.delete();
        repeat (6) tick(0, 100);
        checks++;
        if (count !== CNT_W'(0) || empty !== 1'b1) begin
            failures++; $display("FAIL basic_drain: count=%0d empty=%b, want 0 1", count, empty);
        end
    endtask

    task automatic test_full_stall();
        bit ok;
        send_hdr(8'hC3, 8'd11, 1'b0, ok);
        repeat (14) tick(100, 0);
        checks++;
        if (!ok || obs_q.size() != 10 || count !== CNT_W'(MAX) || full !== 1'b1 || dat_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_stall: hdr_ok=%0b pushes=%0d count=%0d full=%b dat_ready=%b, want 1 10 10 1 0",
                     ok, obs_q.size(), count, full, dat_ready);
        end
        repeat (2) tick(100, 100);
        repeat (6) tick(100, 0);
        checks++;
        if (obs_q.size() != 12 || count !== CNT_W'(MAX) || cpl_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_resume: pushes=%0d count=%0d cpl_ready=%b, want 12 10 1", obs_q.size(), count, cpl_ready);
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].last !== (i == 11) || obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL full_beat[%0d]: last=%b id=%h, want last=%b and model beat", i, obs_q[i].last, obs_q[i].id, (i == 11));
            end
        end
        obs_q.delete(); exp_q.delete();
        repeat (12) tick(0, 100);
    endtask

    task automatic test_full_pop();
        bit ok;
        int n;
        send_hdr(8'h77, 8'd19, 1'b0, ok);
        repeat (14) tick(100, 0);
        tick(100, 100);
        checks++;
        if (!ok || count !== CNT_W'(9) || obs_q.size() != 10) begin
            failures++; $display("FAIL fullpop_first: count=%0d pushes=%0d, want 9 10", count, obs_q.size());
        end
        repeat (6) begin
            tick(100, 100);
            checks++;
            if (count !== CNT_W'(m_occ) || int'(count) < 9 || int'(count) > MAX) begin
                failures++; $display("FAIL fullpop_hold: count=%0d, want %0d within 9..10", count, m_occ);
            end
        end
        n = 0;
        while (cpl_ready !== 1'b1 && n < 100) begin tick(100, 100); n++; end
        checks++;
        if (n >= 100 || obs_q.size() != 20) begin
            failures++; $display("FAIL fullpop_done: pushes=%0d cycles=%0d, want 20 within 100", obs_q.size(), n);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL fullpop_scoreboard: beat %0d differs from model", i);
            end
        end
        checks++;
        if (max_seen > MAX) begin failures++; $display("FAIL fullpop_max: max count %0d, want <= %0d", max_seen, MAX); end
        obs_q.delete(); exp_q.delete();
        repeat (12) tick(0, 100);
    endtask

    task automatic test_err();
        bit ok;
        int rdy_seen;
        send_hdr(8'hE1, 8'd2, 1'b1, ok);
        rdy_seen = 0;
        repeat (8) begin
            tick(100, 0);
            if (dat_ready !== 1'b0) rdy_seen++;
        end
        checks++;
        if (!ok || rdy_seen != 0 || obs_q.size() != 3 || count !== CNT_W'(3)) begin
            failures++;
            $display("FAIL err_burst: hdr_ok=%0b dat_ready_high=%0d pushes=%0d count=%0d, want 1 0 3 3",
                     ok, rdy_seen, obs_q.size(), count);
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].data !== '0 || obs_q[i].resp !== 2'b10 || obs_q[i].id !== 8'hE1 || obs_q[i].last !== (i == 2)) begin
                failures++;
                $display("FAIL err_beat[%0d]: data_nonzero=%b resp=%b id=%h last=%b, want 0 10 e1 %b",
                         i, (obs_q[i].data != '0), obs_q[i].resp, obs_q[i].id, obs_q[i].last, (i == 2));
            end
        end
        obs_q.delete(); exp_q.delete();
        repeat (6) tick(0, 100);
    endtask

    task automatic test_arst_mid();
        bit ok;
        send_hdr(8'h3C, 8'd3, 1'b0, ok);
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) tick(100, 0);
        checks++;
        if (obs_q.size() != 2) begin failures++; $display("FAIL arst_pre: pushes=%0d, want 2", obs_q.size()); end
        arst = 1'b0; dat_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== CNT_W'(0) || empty !== 1'b1 || buf_wr_en !== 1'b0) begin
            failures++; $display("FAIL arst_mid: count=%0d empty=%b wr_en=%b, want 0 1 0", count, empty, buf_wr_en);
        end
        obs_q.delete(); exp_q.delete();
        arst = 1'b1;
        @(negedge clk);
        repeat (3) tick(0, 100);
        checks++;
        if (count !== CNT_W'(0) || cpl_ready !== 1'b1) begin
            failures++; $display("FAIL pop_empty: count=%0d cpl_ready=%b, want 0 1", count, cpl_ready);
        end
        buf_rd_en = 1'b0;
        send_hdr(8'h01, 8'd0, 1'b0, ok);
        repeat (4) tick(100, 0);
        checks++;
        if (!ok || obs_q.size() != 1 || count !== CNT_W'(1)) begin
            failures++; $display("FAIL len0: pushes=%0d count=%0d, want 1 1", obs_q.size(), count);
        end else begin
            checks++;
            if (obs_q[0].last !== 1'b1 || obs_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL len0_beat: last=%b id=%h, want 1 01 and model beat", obs_q[0].last, obs_q[0].id);
            end
        end
        obs_q.delete(); exp_q.delete();
        repeat (4) tick(0, 100);
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 10; it++) begin
            send_hdr(8'($urandom), 8'($urandom_range(15)), ($urandom_range(3) == 0), ok);
            n = 0;
            do begin
                tick(70, 40);
                n++;
                checks++;
                if ({count, full, empty, dat_ready, cpl_ready} !==
                    {CNT_W'(m_occ), (m_occ == MAX), (m_occ == 0), m_dat_ready, m_cpl_ready}) begin
                    failures++;
                    $display("FAIL rand_state[%0d]: count=%0d full=%b empty=%b dat_ready=%b cpl_ready=%b, want %0d %b %b %b %b",
                             it, count, full, empty, dat_ready, cpl_ready, m_occ, (m_occ == MAX), (m_occ == 0),
                             m_dat_ready, m_cpl_ready);
                end
            end while (cpl_ready !== 1'b1 && n < 400);
            checks++;
            if (!ok || n >= 400 || obs_q.size() != exp_q.size()) begin
                failures++;
                $display("FAIL rand_done[%0d]: hdr_ok=%0b cycles=%0d pushes=%0d, want 1 <400 %0d",
                         it, ok, n, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand_scoreboard[%0d]: beat %0d differs from model", it, i);
                end
            end
            obs_q.delete(); exp_q.delete();
        end
        checks++;
        if (max_seen > MAX) begin failures++; $display("FAIL rand_max: max count %0d, want <= %0d", max_seen, MAX); end
    endtask

    initial begin
        arst = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_full_stall();
        test_full_pop();
        test_err();
        test_arst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1);
    end

endmodule
